loss: RTL and testbench
=======================

// Module: loss
// PURPOSE
//  Consumes the sigmoid result stream (res) and a target stream (tgt).
//  Produces the signed error stream (err) that drives the sigmoid backward path.
//  Sits at the output end of a neuron: the sigmoid forward output terminates here, and the backward input originates here.
//  In inference mode it only forwards results to out.
//  In training mode it joins res with tgt, emits err = (res - tgt) scaled, and keeps a running |err| sum.
// PARAMETERS
//  RATE_SHIFT  0   arithmetic right shift applied to err (learning-rate scale)
//  SUM_WIDTH   24  width of the saturating |err| accumulator
// PORTS
//  clock      in   1          single clock, rising edge
//  reset      in   1          asynchronous, active-high
//  train      in   1          mode request: 1 = training, 0 = inference
//  res_valid  in   1          activation stream from sigmoid
//  res_ready  out  1
//  res_data   in   8          unsigned Q0.8 (0x80 = 0.5)
//  tgt_valid  in   1          target stream (training only)
//  tgt_ready  out  1
//  tgt_data   in   8          unsigned Q0.8
//  err_valid  out  1          error stream to sigmoid backward input
//  err_ready  in   1
//  err_data   out  16         signed Q8.8
//  out_valid  out  1          inference result stream
//  out_ready  in   1
//  out_data   out  8          unsigned Q0.8, equal to res_data
//  abs_sum    out  SUM_WIDTH  saturating sum of |err_data|
// BEHAVIOUR
//  - Reset (async): every valid/ready = 0, every data = 0, abs_sum = 0, operand flags cleared, mode = 0.
//  - Reset mid-transfer drops all valids immediately.
//  - Handshake: a transfer occurs on an edge where valid && ready.
//  - Producers hold valid/data until accepted; data is held stable while valid && !ready.
//  - Mode register: latched from train only when IDLE (no operand captured, err/out slot empty).
//    A train change while busy takes effect after the drain.
//    A 0->1 mode transition also clears abs_sum.
//  - Inference (mode = 0):
//    - res_ready = !out_valid; tgt_ready = 0.
//    - Accepted res loads out_data; out_valid rises next cycle.
//    - Throughput is 1 per 2 cycles.
//  - Training (mode = 1): res and tgt each captured into a one-entry slot (flag + data).
//    - res_ready = !res_full; tgt_ready = !tgt_full.
//    - Arrival order is free; both may arrive on the same edge.
//    - When both are full and err_valid = 0, the err register loads on the next edge and both flags clear.
//      err_valid rises exactly one cycle after the later capture edge.
//    - err = ($signed({8'b0,res}) - $signed({8'b0,tgt})) >>> RATE_SHIFT. The result is in -255..255, so there is no overflow.
//    - On each err handshake: abs_sum += |err_data|, saturating at all-ones.
//    - No res is forwarded to out; out_valid stays 0.
//  - err_data and out_data are registered outputs; no combinational path from any input data to any output.
// STRUCTURE
//  - Shared package neuron_pkg:
//    - act_t = logic [7:0], err_t = logic signed [15:0]
//    - mode_e {INFER, TRAIN}
//    - ACT_ONE = 8'hff
//  - Sub-module stream_slot: one-entry valid/ready register (load, drain, full).
//    - Instantiated for the res, tgt, err and out slots.
//  - Top level: the join/IDLE logic, the mode latch, and the accumulator.
// TESTING
//  1. train=0, res 0x80
//     -> out_data 0x80 one cycle later; tgt_ready and err_valid remain 0.
//  2. train=1, res 0xff and tgt 0x00 on the same edge
//     -> next cycle err_data 0x00ff; after the handshake abs_sum = 0xff.
//  3. RATE_SHIFT=1, res 0x00, tgt 0xff
//     -> err_data 0xff80 (-128); abs_sum += 0x80.
//  4. tgt 3 cycles before res; err_ready held low 5 cycles
//     -> err_data stable, tgt_ready low after capture, res_ready low while its slot is full.
//  5. res captured in train mode, train dropped before tgt
//     -> mode stays TRAIN; err emitted; inference resumes only after the err handshake.
//  6. reset pulsed with err_valid=1 and abs_sum nonzero
//     -> err_valid, out_valid and abs_sum read 0 before the next clock edge.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types for the neuron datapath: activation/error formats, mode encoding
// and the operand difference used by the loss stage.
package neuron_pkg;

  typedef logic [7:0]         act_t;
  typedef logic signed [15:0] err_t;

  typedef enum logic {INFER = 1'b0, TRAIN = 1'b1} mode_e;

  localparam act_t ACT_ONE = 8'hff;

  // Both operands are unsigned Q0.8, so the difference always fits in Q8.8.
  function automatic err_t act_diff(input act_t a, input act_t b);
    return $signed({8'b0, a}) - $signed({8'b0, b});
  endfunction

endpackage

// File: rtl/stream_slot.sv
// One-entry valid/ready holding register: load fills it, drain empties it.
// The owner guarantees load is only asserted while the slot is empty.
module stream_slot #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         drain,
  output logic         full,
  output logic [W-1:0] data
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/loss.sv
// Output end of a neuron: forwards sigmoid results in inference, and in training
// joins result with target into a scaled signed error plus a running |err| sum.
module loss
  import neuron_pkg::*;
#(
  parameter int RATE_SHIFT = 0,
  parameter int SUM_WIDTH  = 24
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 train,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [7:0]           res_data,
  input  logic                 tgt_valid,
  output logic                 tgt_ready,
  input  logic [7:0]           tgt_data,
  output logic                 err_valid,
  input  logic                 err_ready,
  output logic [15:0]          err_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic [SUM_WIDTH-1:0] abs_sum
);

  function automatic err_t scale_err(input act_t r, input act_t t);
    return act_diff(r, t) >>> RATE_SHIFT;
  endfunction

  function automatic logic [SUM_WIDTH-1:0] sat_add(input logic [SUM_WIDTH-1:0] sum,
                                                   input err_t e);
    logic [15:0]        mag;
    logic [SUM_WIDTH:0] total;
    mag   = e[15] ? 16'(-e) : 16'(e);
    total = {1'b0, sum} + (SUM_WIDTH+1)'(mag);
    return total[SUM_WIDTH] ? '1 : total[SUM_WIDTH-1:0];
  endfunction

  mode_e mode;
  mode_e eff_mode;
  logic  idle;
  logic  res_full, tgt_full;
  act_t  res_q, tgt_q;
  logic  res_hs, err_hs, out_hs;
  logic  res_load, tgt_load, out_load;
  logic  join_go;
  err_t  err_next;

  assign idle = !res_full && !tgt_full && !err_valid && !out_valid;

  // When idle, the requested mode already steers this cycle's captures so that
  // an operand is never parked in a slot the next mode cannot drain.
  assign eff_mode = idle ? (train ? TRAIN : INFER) : mode;

  always_comb begin
    res_ready = 1'b0;
    tgt_ready = 1'b0;
    if (!reset) begin
      if (eff_mode == TRAIN) begin
        res_ready = !res_full;
        tgt_ready = !tgt_full;
      end else begin
        res_ready = !out_valid;
      end
    end
  end

  assign res_hs   = res_valid && res_ready;
  assign err_hs   = err_valid && err_ready;
  assign out_hs   = out_valid && out_ready;
  assign res_load = res_hs && (eff_mode == TRAIN);
  assign out_load = res_hs && (eff_mode == INFER);
  assign tgt_load = tgt_valid && tgt_ready;
  assign join_go  = res_full && tgt_full && !err_valid;
  assign err_next = scale_err(res_q, tgt_q);

  // Operand capture stage
  stream_slot #(.W(8)) u_res_slot (
    .clock     (clock),
    .reset     (reset),
    .load      (res_load),
    .load_data (res_data),
    .drain     (join_go),
    .full      (res_full),
    .data      (res_q)
  );

  stream_slot #(.W(8)) u_tgt_slot (
    .clock     (clock),
    .reset     (reset),
    .load      (tgt_load),
    .load_data (tgt_data),
    .drain     (join_go),
    .full      (tgt_full),
    .data      (tgt_q)
  );

  // Output register stage
  stream_slot #(.W(16)) u_err_slot (
    .clock     (clock),
    .reset     (reset),
    .load      (join_go),
    .load_data (err_next),
    .drain     (err_hs),
    .full      (err_valid),
    .data      (err_data)
  );

  stream_slot #(.W(8)) u_out_slot (
    .clock     (clock),
    .reset     (reset),
    .load      (out_load),
    .load_data (res_data),
    .drain     (out_hs),
    .full      (out_valid),
    .data      (out_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode    <= INFER;
      abs_sum <= '0;
    end else begin
      if (idle) mode <= eff_mode;
      if (idle && mode == INFER && train)
        abs_sum <= '0;
      else if (err_hs)
        abs_sum <= sat_add(abs_sum, $signed(err_data));
    end
  end

endmodule

// File: tb/tb_loss.sv
// Randomised and directed bench for loss; two instances (unscaled/24-bit sum and
// shift-by-one/10-bit sum) share stimulus and are checked against a queue model.
module tb_loss;
  import neuron_pkg::*;

  localparam int SW1 = 10;
  localparam longint CAP0 = (64'd1 << 24) - 1;
  localparam longint CAP1 = (64'd1 << SW1) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic train = 1'b0;
  logic res_valid = 1'b0, tgt_valid = 1'b0, err_ready = 1'b0, out_ready = 1'b0;
  logic [7:0] res_data = 8'h00, tgt_data = 8'h00;

  logic res_ready0, tgt_ready0, err_valid0, out_valid0;
  logic [15:0] err_data0;
  logic [7:0]  out_data0;
  logic [23:0] abs_sum0;
  logic res_ready1, tgt_ready1, err_valid1, out_valid1;
  logic [15:0] err_data1;
  logic [7:0]  out_data1;
  logic [SW1-1:0] abs_sum1;

  loss #(.RATE_SHIFT(0), .SUM_WIDTH(24)) dut0 (
    .clock(clock), .reset(reset), .train(train),
    .res_valid(res_valid), .res_ready(res_ready0), .res_data(res_data),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready0), .tgt_data(tgt_data),
    .err_valid(err_valid0), .err_ready(err_ready), .err_data(err_data0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .abs_sum(abs_sum0)
  );

  loss #(.RATE_SHIFT(1), .SUM_WIDTH(SW1)) dut1 (
    .clock(clock), .reset(reset), .train(train),
    .res_valid(res_valid), .res_ready(res_ready1), .res_data(res_data),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready1), .tgt_data(tgt_data),
    .err_valid(err_valid1), .err_ready(err_ready), .err_data(err_data1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .abs_sum(abs_sum1)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: pending operands as queues, output slots as flag+value.
  int        m_mode;
  bit [7:0]  q_res[$];
  bit [7:0]  q_tgt[$];
  bit        e_full, o_full;
  int        e_diff;
  bit [7:0]  o_val;
  longint    sum0, sum1;
  bit        m_idle;
  int        m_eff;
  bit        hs_res, hs_tgt, hs_err, hs_out;

  function automatic void model_reset();
    m_mode = 0;
    q_res.delete();
    q_tgt.delete();
    e_full = 0; o_full = 0; e_diff = 0; o_val = 0;
    sum0 = 0; sum1 = 0;
    hs_res = 0; hs_tgt = 0; hs_err = 0; hs_out = 0;
  endfunction

  task automatic compare_all();
    bit x_rr, x_tr;
    int sh;
    m_idle = (q_res.size() == 0) && (q_tgt.size() == 0) && !e_full && !o_full;
    m_eff  = m_idle ? int'(train) : m_mode;
    if (m_eff == 1) begin
      x_rr = (q_res.size() == 0);
      x_tr = (q_tgt.size() == 0);
    end else begin
      x_rr = !o_full;
      x_tr = 1'b0;
    end
    sh = e_diff >>> 1;
    check("res_ready", res_ready0, x_rr);
    check("res_ready_s1", res_ready1, x_rr);
    check("tgt_ready", tgt_ready0, x_tr);
    check("tgt_ready_s1", tgt_ready1, x_tr);
    check("err_valid", err_valid0, e_full);
    check("err_valid_s1", err_valid1, e_full);
    check("out_valid", out_valid0, o_full);
    check("out_valid_s1", out_valid1, o_full);
    if (e_full) begin
      check("err_data", err_data0, e_diff[15:0]);
      check("err_data_s1", err_data1, sh[15:0]);
    end
    if (o_full) begin
      check("out_data", out_data0, o_val);
      check("out_data_s1", out_data1, o_val);
    end
    check("abs_sum", abs_sum0, sum0[23:0]);
    check("abs_sum_s1", abs_sum1, sum1[SW1-1:0]);
    hs_res = res_valid && x_rr;
    hs_tgt = tgt_valid && x_tr;
    hs_err = e_full && err_ready;
    hs_out = o_full && out_ready;
  endtask

  task automatic model_update();
    bit do_join;
    int mag;
    do_join = (q_res.size() > 0) && (q_tgt.size() > 0) && !e_full;
    if (m_idle) begin
      if (train && m_mode == 0) begin
        sum0 = 0;
        sum1 = 0;
      end
      m_mode = int'(train);
    end
    if (hs_err) begin
      mag  = (e_diff < 0) ? -e_diff : e_diff;
      sum0 = (sum0 + mag > CAP0) ? CAP0 : sum0 + mag;
      mag  = e_diff >>> 1;
      mag  = (mag < 0) ? -mag : mag;
      sum1 = (sum1 + mag > CAP1) ? CAP1 : sum1 + mag;
      e_full = 0;
    end
    if (do_join) begin
      e_diff = int'(q_res.pop_front()) - int'(q_tgt.pop_front());
      e_full = 1;
    end
    if (hs_res) begin
      if (m_eff == 1) q_res.push_back(res_data);
      else begin
        o_full = 1;
        o_val  = res_data;
      end
    end
    if (hs_tgt) q_tgt.push_back(tgt_data);
    if (hs_out) o_full = 0;
  endtask

  task automatic step();
    @(negedge clock);
    compare_all();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic retire();
    if (hs_res) res_valid = 1'b0;
    if (hs_tgt) tgt_valid = 1'b0;
  endtask

  function automatic logic [7:0] pick();
    int k;
    k = $urandom_range(0, 7);
    if (k == 0) return 8'h00;
    if (k == 1) return ACT_ONE;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    model_reset();
    #3;
    check("rst_res_ready", res_ready0, 0);
    check("rst_tgt_ready", tgt_ready0, 0);
    check("rst_err_valid", err_valid0, 0);
    check("rst_out_valid", out_valid0, 0);
    check("rst_err_data", err_data0, 0);
    check("rst_out_data", out_data0, 0);
    check("rst_abs_sum", abs_sum0, 0);
    @(posedge clock); #3;
    reset = 1'b0;

    // Inference forwarding
    res_valid = 1'b1; res_data = 8'h80;
    step(); retire();
    check("t1_out_valid", out_valid0, 1);
    check("t1_out_data", out_data0, 8'h80);
    check("t1_tgt_ready", tgt_ready0, 0);
    check("t1_err_valid", err_valid0, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Training: simultaneous operands, full-scale positive error
    train = 1'b1;
    res_valid = 1'b1; res_data = 8'hff;
    tgt_valid = 1'b1; tgt_data = 8'h00;
    step(); retire();
    step();
    check("t2_err_valid", err_valid0, 1);
    check("t2_err_data", err_data0, 16'h00ff);
    check("t2_err_data_s1", err_data1, 16'h007f);
    err_ready = 1'b1;
    step();
    err_ready = 1'b0;
    check("t2_abs_sum", abs_sum0, 24'h0000ff);
    check("t2_abs_sum_s1", abs_sum1, 10'h07f);

    // Full-scale negative error, shifted instance rounds toward -inf
    res_valid = 1'b1; res_data = 8'h00;
    tgt_valid = 1'b1; tgt_data = 8'hff;
    step(); retire();
    step();
    check("t3_err_data_s1", err_data1, 16'hff80);
    check("t3_err_data", err_data0, 16'hff01);
    err_ready = 1'b1;
    step();
    err_ready = 1'b0;
    check("t3_abs_sum_s1", abs_sum1, 10'h0ff);
    check("t3_abs_sum", abs_sum0, 24'h0001fe);

    // Target early, error stalled downstream
    tgt_valid = 1'b1; tgt_data = 8'h40;
    step(); retire();
    tgt_valid = 1'b1; tgt_data = 8'h41;
    step();
    check("t4_tgt_held", tgt_ready0, 0);
    step();
    res_valid = 1'b1; res_data = 8'hc0;
    step(); retire();
    res_valid = 1'b1; res_data = 8'hc1;
    check("t4_res_full", res_ready0, 0);
    step();
    step(); retire();
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_err_stable", err_data0, 16'h0080);
      check("t4_err_valid", err_valid0, 1);
      check("t4_res_blocked", res_ready0, 0);
      check("t4_tgt_blocked", tgt_ready0, 0);
    end
    err_ready = 1'b1;
    step(); step(); step();
    err_ready = 1'b0;

    // Train dropped after a result was captured
    res_valid = 1'b1; res_data = 8'h10;
    step(); retire();
    train = 1'b0;
    step();
    check("t5_still_train", tgt_ready0, 1);
    check("t5_no_out", out_valid0, 0);
    tgt_valid = 1'b1; tgt_data = 8'h20;
    step(); retire();
    step();
    check("t5_err_valid", err_valid0, 1);
    check("t5_err_data", err_data0, 16'hfff0);
    err_ready = 1'b1;
    step();
    err_ready = 1'b0;
    res_valid = 1'b1; res_data = 8'h33;
    step(); retire();
    check("t5_out_valid", out_valid0, 1);
    check("t5_out_data", out_data0, 8'h33);
    check("t5_err_idle", err_valid0, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset while an error is pending and the sum is nonzero
    train = 1'b1;
    res_valid = 1'b1; res_data = 8'h90;
    tgt_valid = 1'b1; tgt_data = 8'h10;
    step(); retire();
    step();
    err_ready = 1'b1;
    step();
    err_ready = 1'b0;
    res_valid = 1'b1; res_data = 8'h50;
    tgt_valid = 1'b1; tgt_data = 8'h10;
    step(); retire();
    step();
    check("t6_pre_err_valid", err_valid0, 1);
    check("t6_pre_abs_sum", abs_sum0, 24'h000080);
    #2;
    reset = 1'b1;
    #1;
    check("t6_err_valid", err_valid0, 0);
    check("t6_err_valid_s1", err_valid1, 0);
    check("t6_out_valid", out_valid0, 0);
    check("t6_abs_sum", abs_sum0, 0);
    check("t6_abs_sum_s1", abs_sum1, 0);
    check("t6_res_ready", res_ready0, 0);
    check("t6_tgt_ready", tgt_ready0, 0);
    check("t6_err_data", err_data0, 0);
    @(posedge clock); #3;
    reset = 1'b0;
    model_reset();

    // Randomised traffic with occasional mode requests
    for (int c = 0; c < 3000; c++) begin
      step();
      if (hs_res || !res_valid) begin
        res_valid = ($urandom_range(0, 1) == 1);
        res_data  = pick();
      end
      if (hs_tgt || !tgt_valid) begin
        tgt_valid = ($urandom_range(0, 1) == 1);
        tgt_data  = pick();
      end
      err_ready = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) train = ~train;
    end
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
